// File: rtl/uart_cmd_asm.sv
// Assembles 3-byte MSB-first commands from a UART receiver and sequences single-byte responses.
// Optional inter-byte timeout built when UART_CMD_ASM_TIMEOUT_EN is defined.
module uart_cmd_asm #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        frame_err
);
    typedef enum logic [1:0] {WAIT_B1, WAIT_B2, WAIT_B3} rx_state_e;
    typedef enum logic {R_IDLE, R_BUSY} rsp_state_e;

    rx_state_e  rx_state_q, rx_state_d;
    rsp_state_e rsp_state_q, rsp_state_d;
    logic [15:0] shadow_q, shadow_d;
    logic [23:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        trmt_q, trmt_d, resp_sent_q, resp_sent_d;
    logic        timeout, cap_b1, cap_b2, cap_b3;

`ifdef UART_CMD_ASM_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;
    logic        frame_err_q;

    assign timeout = (rx_state_q != WAIT_B1) && (cnt_q == TO_LIM);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (rx_rdy || timeout || rx_state_q == WAIT_B1) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            frame_err_q <= timeout;
        end
    end
    assign frame_err = frame_err_q;
`else
    assign timeout   = 1'b0;
    assign frame_err = 1'b0;
`endif

    // Receive FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_q <= WAIT_B1;
        else        rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        if (timeout) begin
            // a byte landing on the timeout cycle starts a fresh command
            rx_state_d = rx_rdy ? WAIT_B2 : WAIT_B1;
        end else if (rx_rdy) begin
            case (rx_state_q)
                WAIT_B1: rx_state_d = WAIT_B2;
                WAIT_B2: rx_state_d = WAIT_B3;
                default: rx_state_d = WAIT_B1;
            endcase
        end
    end

    always_comb begin
        clr_rx_rdy = rx_rdy & rst_n;
        cap_b1     = rx_rdy & (timeout | (rx_state_q == WAIT_B1));
        cap_b2     = rx_rdy & ~timeout & (rx_state_q == WAIT_B2);
        cap_b3     = rx_rdy & ~timeout & (rx_state_q == WAIT_B3);
    end

    always_comb begin
        shadow_d  = timeout ? 16'h0 : shadow_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
        if (cap_b1) shadow_d[15:8] = rx_data;
        if (cap_b2) shadow_d[7:0]  = rx_data;
        if (cap_b3) begin
            cmd_d     = {shadow_q, rx_data};
            cmd_rdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    // Response FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_state_q <= R_IDLE;
        else        rsp_state_q <= rsp_state_d;
    end

    always_comb begin
        rsp_state_d = rsp_state_q;
        case (rsp_state_q)
            R_IDLE:  if (send_resp) rsp_state_d = R_BUSY;
            default: if (tx_done)   rsp_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        if (rsp_state_q == R_IDLE && send_resp) begin
            tx_data_d = resp;
            trmt_d    = 1'b1;
        end
        if (rsp_state_q == R_BUSY && tx_done) resp_sent_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign resp_sent = resp_sent_q;
endmodule

// File: tb/tb_uart_cmd_asm.sv
// Directed bench for uart_cmd_asm: per-cycle vector table plus gap, reset and timeout sequences.
module tb_uart_cmd_asm;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [7:0]  rx_data = '0, resp = '0;
    logic        rx_rdy = 1'b0, clr_cmd_rdy = 1'b0, send_resp = 1'b0, tx_done = 1'b0;
    logic        clr_rx_rdy, cmd_rdy, trmt, resp_sent, frame_err;
    logic [23:0] cmd;
    logic [7:0]  tx_data;

    int n_chk = 0, n_fail = 0, n_clr = 0, n_ferr = 0;
    logic last_clr;

`ifdef UART_CMD_ASM_TIMEOUT_EN
    localparam int GAP = 30;
`else
    localparam int GAP = 100;
`endif

    uart_cmd_asm #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .resp_sent(resp_sent), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rr;   logic [7:0] rd;  logic cc;
        logic        sr;   logic [7:0] rp;  logic td;
        logic        e_clr; logic [23:0] e_cmd; logic e_rdy;
        logic        e_trmt; logic [7:0] e_tx; logic e_sent;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample comb ack before the edge, registered outputs after it
    task automatic cyc(input logic r, input logic [7:0] d, input logic c,
                       input logic s, input logic [7:0] rp, input logic td);
        @(negedge clk);
        rx_rdy = r; rx_data = d; clr_cmd_rdy = c; send_resp = s; resp = rp; tx_done = td;
        #1 last_clr = clr_rx_rdy;
        if (clr_rx_rdy) n_clr++;
        @(posedge clk);
        #1;
        if (frame_err) n_ferr++;
        rx_rdy = 0; clr_cmd_rdy = 0; send_resp = 0; tx_done = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, 8'h00, 0);
    endtask

    task automatic byte_in(input logic [7:0] b);
        cyc(1, b, 0, 0, 8'h00, 0);
    endtask

    vec_t vt[19];

    initial begin
        //       rr  rd     cc sr rp     td  clr cmd          rdy trmt tx     sent
        vt[0]  = '{0, 8'h00, 0, 0, 8'h00, 0,  0, 24'h000000, 0,  0,  8'h00, 0};
        vt[1]  = '{1, 8'hA5, 0, 0, 8'h00, 0,  1, 24'h000000, 0,  0,  8'h00, 0};
        vt[2]  = '{1, 8'h3C, 0, 0, 8'h00, 0,  1, 24'h000000, 0,  0,  8'h00, 0};
        vt[3]  = '{1, 8'h0F, 0, 0, 8'h00, 0,  1, 24'hA53C0F, 1,  0,  8'h00, 0};
        vt[4]  = '{0, 8'h00, 0, 0, 8'h00, 0,  0, 24'hA53C0F, 1,  0,  8'h00, 0};
        vt[5]  = '{0, 8'h00, 1, 0, 8'h00, 0,  0, 24'hA53C0F, 0,  0,  8'h00, 0};
        vt[6]  = '{0, 8'h00, 0, 1, 8'h06, 0,  0, 24'hA53C0F, 0,  1,  8'h06, 0};
        vt[7]  = '{0, 8'h00, 0, 1, 8'h99, 0,  0, 24'hA53C0F, 0,  0,  8'h06, 0};
        vt[8]  = '{0, 8'h00, 0, 0, 8'h00, 1,  0, 24'hA53C0F, 0,  0,  8'h06, 1};
        vt[9]  = '{0, 8'h00, 0, 0, 8'h00, 0,  0, 24'hA53C0F, 0,  0,  8'h06, 0};
        vt[10] = '{1, 8'h12, 0, 0, 8'h00, 0,  1, 24'hA53C0F, 0,  0,  8'h06, 0};
        vt[11] = '{1, 8'h34, 0, 0, 8'h00, 0,  1, 24'hA53C0F, 0,  0,  8'h06, 0};
        vt[12] = '{1, 8'h56, 0, 0, 8'h00, 0,  1, 24'h123456, 1,  0,  8'h06, 0};
        vt[13] = '{1, 8'h00, 0, 0, 8'h00, 0,  1, 24'h123456, 1,  0,  8'h06, 0};
        vt[14] = '{1, 8'hFF, 0, 0, 8'h00, 0,  1, 24'h123456, 1,  0,  8'h06, 0};
        vt[15] = '{1, 8'h01, 1, 0, 8'h00, 0,  1, 24'h00FF01, 1,  0,  8'h06, 0};
        vt[16] = '{1, 8'h01, 0, 1, 8'h42, 0,  1, 24'h00FF01, 1,  1,  8'h42, 0};
        vt[17] = '{1, 8'h02, 0, 0, 8'h00, 0,  1, 24'h00FF01, 1,  0,  8'h42, 0};
        vt[18] = '{1, 8'h03, 0, 0, 8'h00, 1,  1, 24'h010203, 1,  0,  8'h42, 1};

        // reset state, with rx_rdy asserted to confirm the ack is suppressed
        rx_rdy = 1;
        #12;
        chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 0);
        chk("rst_cmd", 32'(cmd), 0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_trmt", 32'(trmt), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        rx_rdy = 0;
        @(negedge clk) rst_n = 1;

        for (int i = 0; i < 19; i++) begin
            cyc(vt[i].rr, vt[i].rd, vt[i].cc, vt[i].sr, vt[i].rp, vt[i].td);
            chk($sformatf("v%0d_clr_rx_rdy", i), 32'(last_clr), 32'(vt[i].e_clr));
            chk($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vt[i].e_cmd));
            chk($sformatf("v%0d_cmd_rdy", i), 32'(cmd_rdy), 32'(vt[i].e_rdy));
            chk($sformatf("v%0d_trmt", i), 32'(trmt), 32'(vt[i].e_trmt));
            chk($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vt[i].e_tx));
            chk($sformatf("v%0d_resp_sent", i), 32'(resp_sent), 32'(vt[i].e_sent));
            chk($sformatf("v%0d_frame_err", i), 32'(frame_err), 0);
        end
        idle(1);
        chk("post_trmt_pulse", 32'(trmt), 0);
        chk("post_sent_pulse", 32'(resp_sent), 0);

        // spaced bytes: exactly one ack per byte, cmd lands right after byte3
        cyc(0, 8'h00, 1, 0, 8'h00, 0);
        n_clr = 0;
        byte_in(8'hA5); idle(GAP);
        chk("gap_mid_cmd_hold", 32'(cmd), 32'h010203);
        byte_in(8'h3C); idle(GAP);
        byte_in(8'h0F);
        chk("gap_cmd", 32'(cmd), 32'hA53C0F);
        chk("gap_cmd_rdy", 32'(cmd_rdy), 1);
        idle(GAP);
        chk("gap_ack_count", 32'(n_clr), 3);
        cyc(0, 8'h00, 1, 0, 8'h00, 0);
        chk("gap_clr_rdy", 32'(cmd_rdy), 0);
        chk("gap_clr_cmd_hold", 32'(cmd), 32'hA53C0F);

        // reset after byte1 discards it
        byte_in(8'h77);
        @(negedge clk) rst_n = 0;
        #1 chk("midrst_cmd", 32'(cmd), 0);
        @(negedge clk) rst_n = 1;
        byte_in(8'h01); byte_in(8'h02); byte_in(8'h03);
        chk("midrst_new_cmd", 32'(cmd), 32'h010203);
        chk("midrst_rdy", 32'(cmd_rdy), 1);

        // long silence after byte1
        n_ferr = 0;
        byte_in(8'h11); idle(60);
`ifdef UART_CMD_ASM_TIMEOUT_EN
        chk("to_frame_err_count", 32'(n_ferr), 1);
        chk("to_cmd_hold", 32'(cmd), 32'h010203);
        chk("to_rdy_hold", 32'(cmd_rdy), 1);
        byte_in(8'hAA); byte_in(8'hBB); byte_in(8'hCC);
        chk("to_cmd", 32'(cmd), 32'hAABBCC);
        // byte presented on the exact timeout cycle becomes byte1
        n_ferr = 0;
        byte_in(8'h11); idle(50);
        byte_in(8'hDD);
        chk("to_edge_frame_err", 32'(n_ferr), 1);
        byte_in(8'hEE); byte_in(8'hFF);
        chk("to_edge_cmd", 32'(cmd), 32'hDDEEFF);
`else
        byte_in(8'hAA); byte_in(8'hBB);
        chk("nto_cmd", 32'(cmd), 32'h11AABB);
        chk("nto_frame_err_count", 32'(n_ferr), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1);
    end
endmodule
